apb_master_gen2: RTL and testbench

Parametrised APB4 master: accepts one request at a time over a valid/ready command port, runs a SETUP/ACCESS transfer on the APB bus with byte strobes, and returns read data and slave error on a response port. It is the next-generation bus-facing master between a local requester and APB slaves. Unlike the first-generation master, it adds:

- configurable address and data widths
- back-to-back transfers without an IDLE gap
- PSTRB and PSLVERR
- an optional access timeout

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_master_gen2_if.sv | 41 ++++
 rtl/apb_timeout_ctr.sv | 30 +++
 rtl/apb_master_gen2.sv | 124 ++++++++++++
 tb/tb_apb_master_gen2.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared state encoding, defaults and request record for the APB4 master family.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   localparam int unsigned APB_TIMEOUT_DEF = 16;

   localparam int unsigned REQ_ADDR_W = 32;
   localparam int unsigned REQ_DATA_W = 32;
   localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

   typedef struct packed {
      logic                  write;
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic [REQ_STRB_W-1:0] strb;
   } apb_req_t;

endpackage

// File: rtl/apb_master_gen2_if.sv
// Command/response port and APB4 bus of apb_master_gen2, grouped for both sides.
interface apb_master_gen2_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_strb;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [STRB_W-1:0] PSTRB;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;
   logic              PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_strb,
      input  PREADY, PRDATA, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_strb,
      output PREADY, PRDATA, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE
   );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles; expired flags the last cycle the slave may still answer.
module apb_timeout_ctr
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] r_cnt;

   // The master aborts on expiry, so the count never needs to wrap.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_master_gen2.sv
// APB4 master: one request at a time, back-to-back capable, strobes and slave error.
// Optional access timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_gen2
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   apb_master_gen2_if.master bus
);
   localparam int unsigned STRB_W = DATA_W / 8;

   apb_state_e        r_state;
   apb_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [STRB_W-1:0] r_pstrb;
   logic              r_pwrite;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              w_req_ready;
   logic              w_psel;
   logic              w_penable;
   logic              w_complete;
   logic              w_timeout;
   logic              w_accept;

   assign w_complete = (r_state == ACCESS) && bus.PREADY;
   assign w_accept   = bus.req_valid && w_req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   logic w_expired;

   apb_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst     (rst),
      .clear   (r_state == SETUP),
      .inc     ((r_state == ACCESS) && !bus.PREADY),
      .expired (w_expired)
   );

   // A slave answering on the terminal cycle still completes normally.
   assign w_timeout = (r_state == ACCESS) && !bus.PREADY && w_expired;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYC;
   assign w_timeout        = 1'b0;
`endif

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_psel      = (r_state != IDLE);
      w_penable   = (r_state == ACCESS);
      case (r_state)
         IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) w_state_nxt = SETUP;
         end
         SETUP:   w_state_nxt = ACCESS;
         ACCESS: begin
            if (w_complete) begin
               w_req_ready = 1'b1;
               w_state_nxt = bus.req_valid ? SETUP : IDLE;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: reset is sampled on the clock edge, and state uses non-blocking updates.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_pwrite    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pwrite <= bus.req_write;
            r_paddr  <= bus.req_addr;
            r_pwdata <= bus.req_write ? bus.req_wdata : '0;
            r_pstrb  <= bus.req_write ? bus.req_strb : '0;
         end
         r_rsp_valid <= w_complete || w_timeout;
         if (w_complete) begin
            r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
            r_rsp_err   <= bus.PSLVERR;
         end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.PADDR     = r_paddr;
   assign bus.PWDATA    = r_pwdata;
   assign bus.PSTRB     = r_pstrb;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PSEL      = w_psel;
   assign bus.PENABLE   = w_penable;

endmodule

// File: tb/tb_apb_master_gen2.sv
// Bench for apb_master_gen2: word-memory reference model, wait/error APB slave model,
// directed protocol steps followed by randomized traffic.
module tb_apb_master_gen2;
   import apb_pkg::*;

   localparam int unsigned ADDR_W      = REQ_ADDR_W;
   localparam int unsigned DATA_W      = REQ_DATA_W;
   localparam int unsigned TIMEOUT_CYC = 4;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      apb_req_t    req;
      int unsigned wait_c;
      bit          err;
      int unsigned gap;
   } txn_t;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } rsp_t;

   typedef struct {
      int unsigned wait_c;
      bit          err;
   } slv_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   apb_master_gen2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_master_gen2 #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int n_total = 0;
   int n_pass  = 0;

   txn_t              txq[$];
   rsp_t              exp_q[$];
   apb_req_t          bus_q[$];
   slv_t              slv_q[$];
   logic [DATA_W-1:0] ref_mem[16];
   logic [DATA_W-1:0] smem[16];
   logic              tr_psel[$];
   logic              tr_pen[$];
   int                acc_cyc[$];
   int                rsp_cyc[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [3:0] strb);
      merge = old;
      for (int b = 0; b < 4; b++) if (strb[b]) merge[8*b +: 8] = wdata[8*b +: 8];
   endfunction

   task automatic add(input bit w, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int unsigned wait_c, input bit err,
                      input int unsigned gap);
      txn_t t;
      t.req.write = w;
      t.req.addr  = addr;
      t.req.wdata = wdata;
      t.req.strb  = strb;
      t.wait_c    = wait_c;
      t.err       = err;
      t.gap       = gap;
      txq.push_back(t);
   endtask

   // APB slave: per-transfer wait states and error taken from slv_q, word memory behind it.
   bit          s_in_acc = 1'b0;
   slv_t        s_cur;
   int unsigned s_wcnt = 0;
   initial begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = '0;
      bus.PSLVERR = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst || !(bus.PSEL && bus.PENABLE)) begin
            s_in_acc    = 1'b0;
            bus.PREADY  = 1'b0;
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom_range(0, 1));
         end else begin
            if (!s_in_acc) begin
               s_in_acc = 1'b1;
               s_wcnt   = 0;
               if (slv_q.size() > 0) s_cur = slv_q.pop_front();
               else begin s_cur.wait_c = 0; s_cur.err = 1'b0; end
            end
            if (s_wcnt < s_cur.wait_c) begin
               s_wcnt++;
               bus.PREADY  = 1'b0;
               bus.PRDATA  = $urandom;
               bus.PSLVERR = 1'($urandom_range(0, 1));
            end else begin
               bus.PREADY  = 1'b1;
               bus.PSLVERR = s_cur.err;
               if (bus.PWRITE) begin
                  bus.PRDATA = $urandom;
                  smem[bus.PADDR[5:2]] = merge(smem[bus.PADDR[5:2]], bus.PWDATA, bus.PSTRB);
               end else begin
                  bus.PRDATA = smem[bus.PADDR[5:2]];
               end
               s_in_acc = 1'b0;
            end
         end
      end
   end

   // Issues everything in txq, tracing PSEL/PENABLE and accept/response cycles.
   task automatic run_txns(input int budget);
      int          cyc;
      int unsigned gap_left;
      txn_t        t;
      rsp_t        e;
      apb_req_t    b;
      bit          to;
      cyc = 0;
      tr_psel.delete(); tr_pen.delete(); acc_cyc.delete(); rsp_cyc.delete();
      gap_left = (txq.size() > 0) ? txq[0].gap : 0;
      while ((txq.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(negedge clk);
         if (txq.size() > 0 && gap_left == 0) begin
            bus.req_valid = 1'b1;
            bus.req_write = txq[0].req.write;
            bus.req_addr  = txq[0].req.addr;
            bus.req_wdata = txq[0].req.wdata;
            bus.req_strb  = txq[0].req.strb;
         end else begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.req_strb  = 4'($urandom);
         end
         #4;
         if (bus.PSEL) begin
            if (bus_q.size() > 0)
               check("bus_fields", {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
                     {bus_q[0].write, bus_q[0].addr, bus_q[0].wdata, bus_q[0].strb});
            else
               check("bus_spurious_psel", bus.PSEL, 1'b0);
         end
         if (bus.req_valid && bus.req_ready) begin
            t  = txq.pop_front();
            to = TO_EN && (t.wait_c >= TIMEOUT_CYC);
            e.err   = to ? 1'b1 : t.err;
            e.rdata = (t.req.write || to) ? '0 : ref_mem[t.req.addr[5:2]];
            if (t.req.write && !to)
               ref_mem[t.req.addr[5:2]] = merge(ref_mem[t.req.addr[5:2]], t.req.wdata, t.req.strb);
            b = t.req;
            if (!t.req.write) begin b.wdata = '0; b.strb = '0; end
            exp_q.push_back(e);
            bus_q.push_back(b);
            slv_q.push_back('{t.wait_c, t.err});
            acc_cyc.push_back(cyc);
            gap_left = (txq.size() > 0) ? txq[0].gap : 0;
         end else if (!bus.req_valid && gap_left > 0) begin
            gap_left--;
         end
         @(posedge clk);
         #1;
         tr_psel.push_back(bus.PSEL);
         tr_pen.push_back(bus.PENABLE);
         if (bus.rsp_valid) begin
            rsp_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rsp_rdata", bus.rsp_rdata, e.rdata);
               check("rsp_err", bus.rsp_err, e.err);
               if (bus_q.size() > 0) void'(bus_q.pop_front());
            end else begin
               check("rsp_spurious", bus.rsp_valid, 1'b0);
            end
         end
         cyc++;
      end
      bus.req_valid = 1'b0;
      check("drain_outstanding", txq.size() + exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   int a;
   int unsigned r_wait;
   initial begin
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_strb  = '0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         smem[i]    = ref_mem[i];
      end
      ref_mem[8] = 32'h1234_5678;
      smem[8]    = 32'h1234_5678;

      // Reset: everything low while held.
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err}, 5'b0);
      check("reset_data", {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.rsp_rdata}, '0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset_req_ready", bus.req_ready, 1'b1);

      // Single zero-wait write: SETUP, ACCESS, response in the third cycle after accept.
      add(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0);
      run_txns(20);
      a = acc_cyc[0];
      check("wr_setup", {tr_psel[a], tr_pen[a]}, 2'b10);
      check("wr_access", {tr_psel[a+1], tr_pen[a+1]}, 2'b11);
      check("wr_back_idle", {tr_psel[a+2], tr_pen[a+2]}, 2'b00);
      check("wr_latency", rsp_cyc[0] - a, 2);

      // Read with three wait states: PENABLE high for four cycles.
      add(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 0);
      run_txns(30);
      a = acc_cyc[0];
      check("rd_penable_hold", {tr_pen[a+1], tr_pen[a+2], tr_pen[a+3], tr_pen[a+4]}, 4'b1111);
      check("rd_penable_drop", tr_pen[a+5], 1'b0);
      check("rd_latency", rsp_cyc[0] - a, 5);

      // Two back-to-back writes: PSEL held, PENABLE 0,1,0,1, responses two cycles apart.
      add(1'b1, 32'h04, 32'hA5A5_0001, 4'h3, 0, 1'b0, 0);
      add(1'b1, 32'h08, 32'h5A5A_0002, 4'hC, 0, 1'b0, 0);
      run_txns(30);
      a = acc_cyc[0];
      check("b2b_psel", {tr_psel[a], tr_psel[a+1], tr_psel[a+2], tr_psel[a+3]}, 4'b1111);
      check("b2b_penable", {tr_pen[a], tr_pen[a+1], tr_pen[a+2], tr_pen[a+3]}, 4'b0101);
      check("b2b_accept_gap", acc_cyc[1] - acc_cyc[0], 2);
      check("b2b_rsp_gap", rsp_cyc[1] - rsp_cyc[0], 2);

      // Read returning PSLVERR.
      add(1'b0, 32'h10, 32'h0, 4'h0, 1, 1'b1, 0);
      run_txns(20);
      check("slverr_rsp_count", rsp_cyc.size(), 1);

      // Reset while in ACCESS: bus drops at once, no response follows.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h30;
      bus.req_wdata = $urandom;
      bus.req_strb  = 4'hF;
      slv_q.push_back('{2, 1'b0});
      #4;
      check("rst_mid_accept", bus.req_ready, 1'b1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_bus_drop", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b000);
      @(negedge clk);
      rst = 1'b1;
      slv_q.delete(); exp_q.delete(); bus_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_mid_no_rsp", bus.rsp_valid, 1'b0);
      end
      add(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 0);
      run_txns(20);
      check("rst_mid_recover", rsp_cyc.size(), 1);

`ifdef APB_MASTER_TIMEOUT_EN
      // Silent slave: abort after TIMEOUT_CYC ACCESS cycles, next request from IDLE.
      add(1'b0, 32'h14, 32'h0, 4'h0, 50, 1'b0, 0);
      add(1'b1, 32'h18, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 1);
      run_txns(60);
      a = acc_cyc[0];
      check("to_access_len", {tr_pen[a+1], tr_pen[a+2], tr_pen[a+3], tr_pen[a+4]}, 4'b1111);
      check("to_bus_drop", {tr_psel[a+5], tr_pen[a+5]}, 2'b00);
      check("to_rsp_cycle", rsp_cyc[0] - a, 5);
      check("to_next_from_idle", acc_cyc[1] - a, 6);
      check("to_next_latency", rsp_cyc[1] - acc_cyc[1], 2);
`endif

      // Random traffic against the memory model.
      for (int i = 0; i < 30; i++) begin
         r_wait = $urandom_range(0, 2);
         if (TO_EN && $urandom_range(0, 7) == 0) r_wait = TIMEOUT_CYC + 2;
         add(1'($urandom_range(0, 1)), {26'd0, 4'($urandom), 2'b00}, $urandom, 4'($urandom),
             r_wait, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      end
      run_txns(600);
      check("rand_rsp_count", rsp_cyc.size(), 30);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
